// File: rtl/pcr_host_initiator.sv
// Host-side initiator for the PCR request/reply port: one outstanding read or write at a time.
// Optional WAIT-state timeout is built when PCR_TIMEOUT_EN is defined.
module pcr_host_initiator #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              pcr_req_valid,
    input  logic              pcr_req_ready,
    output logic              pcr_req_rw,
    output logic [ADDR_W-1:0] pcr_req_addr,
    output logic [DATA_W-1:0] pcr_req_data,
    input  logic              pcr_rep_valid,
    input  logic [DATA_W-1:0] pcr_rep_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              stray_rep
);
    // state | meaning
    // IDLE  | ready to accept a host command
    // REQ   | request presented to core, waiting for pcr_req_ready
    // WAIT  | request accepted by core, waiting for reply strobe
    // RESP  | response presented to host, waiting for resp_ready
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   timeout;

`ifdef PCR_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == REQ && pcr_req_ready)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 16'd1;
    end

    // A reply in the final WAIT cycle takes priority over the timeout.
    assign timeout = (state == WAIT) && !pcr_rep_valid &&
                     (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            resp_err <= 1'b0;
        else if (state == WAIT && (pcr_rep_valid || timeout))
            resp_err <= timeout;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)                 state_nxt = REQ;
            REQ:     if (pcr_req_ready)             state_nxt = WAIT;
            WAIT:    if (pcr_rep_valid || timeout)  state_nxt = RESP;
            RESP:    if (resp_ready)                state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    assign cmd_ready     = (state == IDLE);
    assign pcr_req_valid = (state == REQ);
    assign resp_valid    = (state == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcr_req_rw   <= 1'b0;
            pcr_req_addr <= '0;
            pcr_req_data <= '0;
            resp_data    <= '0;
            stray_rep    <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                pcr_req_rw   <= cmd_rw;
                pcr_req_addr <= cmd_addr;
                pcr_req_data <= cmd_data;
            end
            if (state == WAIT && pcr_rep_valid)
                resp_data <= pcr_rep_data;
            else if (timeout)
                resp_data <= '0;
            // Replies outside WAIT are dropped; only the sticky flag records them.
            if (pcr_rep_valid && state != WAIT)
                stray_rep <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcr_host_initiator.sv
// Directed self-checking bench for pcr_host_initiator; timeout cases run when PCR_TIMEOUT_EN is defined.
module tb_pcr_host_initiator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic        pcr_req_valid, pcr_req_ready = 1'b0, pcr_req_rw;
    logic [4:0]  pcr_req_addr;
    logic [63:0] pcr_req_data;
    logic        pcr_rep_valid = 1'b0;
    logic [63:0] pcr_rep_data = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err, stray_rep;
    logic [63:0] resp_data;

    int n_cmp = 0;
    int n_mis = 0;
    int hs_cnt = 0;

    pcr_host_initiator #(.ADDR_W(5), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_rep_valid(pcr_rep_valid), .pcr_rep_data(pcr_rep_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .stray_rep(stray_rep)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset_n && pcr_req_valid && pcr_req_ready) hs_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string tag, input logic rw, input logic [4:0] a, input logic [63:0] d,
                       input int req_stall, input int rep_dly, input logic [63:0] rep,
                       input int resp_stall, input bit inj_req, input bit inj_resp);
        int hs0;
        hs0 = hs_cnt;
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        tick;
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~a; cmd_data = ~d;
        chk({tag, " cmd_ready busy"}, cmd_ready, 0);
        for (int i = 0; i <= req_stall; i++) begin
            chk({tag, " req_valid"}, pcr_req_valid, 1);
            chk({tag, " req_rw"}, pcr_req_rw, rw);
            chk({tag, " req_addr"}, pcr_req_addr, a);
            chk({tag, " req_data"}, pcr_req_data, d);
            pcr_req_ready = (i == req_stall);
            if (inj_req && i == req_stall) begin
                pcr_rep_valid = 1'b1; pcr_rep_data = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            tick;
            pcr_rep_valid = 1'b0;
        end
        pcr_req_ready = 1'b0;
        chk({tag, " req_valid drop"}, pcr_req_valid, 0);
        chk({tag, " req handshakes"}, 64'(hs_cnt - hs0), 1);
        for (int i = 0; i < rep_dly; i++) begin
            chk({tag, " resp_valid wait"}, resp_valid, 0);
            tick;
        end
        pcr_rep_valid = 1'b1; pcr_rep_data = rep;
        tick;
        pcr_rep_valid = 1'b0; pcr_rep_data = ~rep;
        for (int j = 0; j <= resp_stall; j++) begin
            chk({tag, " resp_valid"}, resp_valid, 1);
            chk({tag, " resp_data"}, resp_data, rep);
            chk({tag, " resp_err"}, resp_err, 0);
            chk({tag, " cmd_ready resp"}, cmd_ready, 0);
            resp_ready = (j == resp_stall);
            if (inj_resp && j == 0) begin
                pcr_rep_valid = 1'b1; pcr_rep_data = 64'h5A5A_5A5A_5A5A_5A5A;
            end
            tick;
            pcr_rep_valid = 1'b0;
        end
        resp_ready = 1'b0;
        chk({tag, " cmd_ready back"}, cmd_ready, 1);
        chk({tag, " resp_valid drop"}, resp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst req_valid", pcr_req_valid, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst stray", stray_rep, 0);
        chk("rst resp_data", resp_data, 0);
        reset_n = 1'b1;
        tick;

        txn("t1_read", 1'b0, 5'h03, 64'h0, 0, 1, 64'h0000_0000_0000_00A5, 0, 0, 0);
        txn("t2_write", 1'b1, 5'h1F, 64'hDEAD_BEEF_0123_4567, 4, 0, 64'h1111_2222_3333_4444, 0, 0, 0);
        txn("t3_resp_bp", 1'b0, 5'h0A, 64'h0, 0, 0, 64'hCAFE_F00D_0000_0007, 3, 0, 0);
        chk("t3 stray clear", stray_rep, 0);

        pcr_rep_valid = 1'b1; pcr_rep_data = 64'h1234;
        tick;
        pcr_rep_valid = 1'b0;
        chk("t4 stray set", stray_rep, 1);
        chk("t4 cmd_ready", cmd_ready, 1);
        chk("t4 resp_valid", resp_valid, 0);
        chk("t4 resp_data kept", resp_data, 64'hCAFE_F00D_0000_0007);
        txn("t4_read", 1'b0, 5'h11, 64'h0, 0, 2, 64'h0123_4567_89AB_CDEF, 1, 0, 0);
        chk("t4 stray sticky", stray_rep, 1);

        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 5'h07; cmd_data = 64'h77; pcr_req_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        pcr_req_ready = 1'b0;
        chk("t6 in wait req_valid", pcr_req_valid, 0);
        chk("t6 in wait resp_valid", resp_valid, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 cmd_ready", cmd_ready, 1);
        chk("t6 req_valid", pcr_req_valid, 0);
        chk("t6 resp_valid", resp_valid, 0);
        chk("t6 resp_err", resp_err, 0);
        chk("t6 stray", stray_rep, 0);
        chk("t6 req_rw", pcr_req_rw, 0);
        chk("t6 req_addr", pcr_req_addr, 0);
        chk("t6 req_data", pcr_req_data, 0);
        chk("t6 resp_data", resp_data, 0);
        #1 reset_n = 1'b1;
        tick;
        pcr_rep_valid = 1'b1; pcr_rep_data = 64'h7777;
        tick;
        pcr_rep_valid = 1'b0;
        chk("t6 late reply stray", stray_rep, 1);
        chk("t6 late reply idle", cmd_ready, 1);
        txn("t6_read", 1'b0, 5'h05, 64'h0, 1, 0, 64'h0000_0000_0000_0055, 0, 0, 0);

        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick;
        chk("t7 stray clear", stray_rep, 0);
        txn("t7_inject", 1'b1, 5'h10, 64'hFEED_0000_0000_0001, 0, 1, 64'h0000_0000_AAAA_5555, 2, 1, 1);
        chk("t7 stray set", stray_rep, 1);

`ifdef PCR_TIMEOUT_EN
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick;
        txn("t8_reply_wins", 1'b0, 5'h02, 64'h0, 0, 7, 64'h0000_0000_0000_8888, 0, 0, 0);
        chk("t8 stray clear", stray_rep, 0);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 5'h04;
        tick;
        cmd_valid = 1'b0; pcr_req_ready = 1'b1;
        tick;
        pcr_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t5 no resp yet", resp_valid, 0);
            tick;
        end
        chk("t5 timeout resp_valid", resp_valid, 1);
        chk("t5 timeout err", resp_err, 1);
        chk("t5 timeout data", resp_data, 0);
        chk("t5 stray before", stray_rep, 0);
        tick;
        pcr_rep_valid = 1'b1; pcr_rep_data = 64'h9999;
        tick;
        pcr_rep_valid = 1'b0;
        chk("t5 late stray", stray_rep, 1);
        chk("t5 resp held", resp_valid, 1);
        chk("t5 data held", resp_data, 0);
        chk("t5 err held", resp_err, 1);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk("t5 cmd_ready back", cmd_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
